// File: rtl/pkt_mux_pkg.sv
// Shared widths, header codes, source indices and arbiter state type for the packet mux.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pkt_mux_pkg;

    localparam int DATA_W  = 134;
    localparam int ENTRY_W = DATA_W + 1;   // packet word plus stored keep flag
    localparam int NUM_SRC = 3;

    localparam logic [1:0] HDR_FIRST = 2'b01;
    localparam logic [1:0] HDR_MID   = 2'b11;
    localparam logic [1:0] HDR_LAST  = 2'b10;

    localparam logic [1:0] SRC_PGM = 2'd0;
    localparam logic [1:0] SRC_LCM = 2'd1;
    localparam logic [1:0] SRC_SSM = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Round-robin successor over the three sources.
    function automatic logic [1:0] src_next(input logic [1:0] s);
        return (s == SRC_SSM) ? SRC_PGM : s + 2'd1;
    endfunction

    function automatic logic is_last(input logic [DATA_W-1:0] d);
        return d[DATA_W-1 -: 2] == HDR_LAST;
    endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous show-ahead FIFO with full/empty/count; head word visible without a read.
// Latency: a write is visible at rd_data the cycle after it is accepted.
// Backpressure: writes while full and reads while empty are ignored.
module pkt_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 135
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/pkt_mux_arb.sv
// Merges whole packets from pgm/lcm/ssm onto one output, round-robin per packet.
// Latency: grant seen in IDLE at cycle N -> first output word at N+2; one idle cycle between packets.
// Backpressure: per-source ready when >= MAX_PKT_WORDS free; pktout_data_ready gates packet starts only.
module pkt_mux_arb
    import pkt_mux_pkg::*;
#(
    parameter int FIFO_DEPTH    = 64,
    parameter int MAX_PKT_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pgm2mux_data,
    input  logic              pgm2mux_data_wr,
    input  logic              pgm2mux_data_valid,
    input  logic              pgm2mux_data_valid_wr,
    output logic              mux2pgm_data_ready,
    input  logic [DATA_W-1:0] lcm2mux_data,
    input  logic              lcm2mux_data_wr,
    input  logic              lcm2mux_data_valid,
    input  logic              lcm2mux_data_valid_wr,
    output logic              mux2lcm_data_ready,
    input  logic [DATA_W-1:0] ssm2mux_data,
    input  logic              ssm2mux_data_wr,
    input  logic              ssm2mux_data_valid,
    input  logic              ssm2mux_data_valid_wr,
    output logic              mux2ssm_data_ready,
    output logic [DATA_W-1:0] pktout_data,
    output logic              pktout_data_wr,
    output logic              pktout_data_valid,
    output logic              pktout_data_valid_wr,
    input  logic              pktout_data_ready,
    output logic [2:0]        err_overflow
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0]  in_data    [NUM_SRC];
    logic [NUM_SRC-1:0] in_wr;
    logic [NUM_SRC-1:0] in_keep;
    logic [NUM_SRC-1:0] in_eop;

    logic [ENTRY_W-1:0] fifo_head  [NUM_SRC];
    logic [NUM_SRC-1:0] fifo_full;
    logic [NUM_SRC-1:0] fifo_empty;
    logic [CNT_W-1:0]   fifo_cnt   [NUM_SRC];

    logic [CNT_W-1:0]   pkt_cnt    [NUM_SRC];
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] pop_vec;
    logic [NUM_SRC-1:0] dec;
    logic [NUM_SRC-1:0] rdy_q;
    logic [NUM_SRC-1:0] err_q;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         grant;
    logic [1:0]         grant_nxt;
    logic [1:0]         rr_ptr;
    logic [1:0]         rr_nxt;
    logic [1:0]         pick;
    logic               found;
    logic [ENTRY_W-1:0] head_sel;
    logic               empty_sel;
    logic               pop;
    logic               pop_last;

    assign in_data[0] = pgm2mux_data;
    assign in_data[1] = lcm2mux_data;
    assign in_data[2] = ssm2mux_data;
    assign in_wr      = {ssm2mux_data_wr,       lcm2mux_data_wr,       pgm2mux_data_wr};
    assign in_keep    = {ssm2mux_data_valid,    lcm2mux_data_valid,    pgm2mux_data_valid};
    assign in_eop     = {ssm2mux_data_valid_wr, lcm2mux_data_valid_wr, pgm2mux_data_valid_wr};

    assign mux2pgm_data_ready = rdy_q[0];
    assign mux2lcm_data_ready = rdy_q[1];
    assign mux2ssm_data_ready = rdy_q[2];
    assign err_overflow       = err_q;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        // Keep flag is captured only alongside the end-of-packet strobe.
        pkt_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (ENTRY_W)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (in_wr[g]),
            .wr_data ({in_keep[g] & in_eop[g], in_data[g]}),
            .rd_en   (pop_vec[g]),
            .rd_data (fifo_head[g]),
            .full    (fifo_full[g]),
            .empty   (fifo_empty[g]),
            .count   (fifo_cnt[g])
        );
        assign pop_vec[g] = pop && (grant == 2'(g));
        assign dec[g]     = pop_last && (grant == 2'(g));
        assign pend[g]    = (pkt_cnt[g] != '0);
    end

    // Select the granted source's head word and empty flag.
    always_comb begin
        head_sel  = fifo_head[0];
        empty_sel = fifo_empty[0];
        case (grant)
            SRC_LCM: begin head_sel = fifo_head[1]; empty_sel = fifo_empty[1]; end
            SRC_SSM: begin head_sel = fifo_head[2]; empty_sel = fifo_empty[2]; end
            default: begin head_sel = fifo_head[0]; empty_sel = fifo_empty[0]; end
        endcase
    end

    // Whole packets are already buffered, so SEND pops every cycle; the empty guard is only a safety net.
    assign pop      = (state == ST_SEND) && !empty_sel;
    assign pop_last = pop && is_last(head_sel[DATA_W-1:0]);

    // Round-robin scan: first source with a complete packet, starting at rr_ptr.
    always_comb begin
        logic [1:0] idx;
        pick  = rr_ptr;
        found = 1'b0;
        idx   = rr_ptr;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && pend[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
            idx = src_next(idx);
        end
    end

    // Next-state logic: IDLE waits for a packet and downstream ready, SEND runs to the last word.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt    = rr_ptr;
        case (state)
            ST_IDLE: begin
                if (pktout_data_ready && found) begin
                    grant_nxt = pick;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (pop_last) begin
                    rr_nxt    = src_next(grant);
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            grant  <= SRC_PGM;
            rr_ptr <= SRC_PGM;
        end else begin
            state  <= state_nxt;
            grant  <= grant_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    // Per-source packet counts, registered ready and sticky overflow flags.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rst) begin
                pkt_cnt[i] <= '0;
                rdy_q[i]   <= 1'b0;
                err_q[i]   <= 1'b0;
            end else begin
                if (in_eop[i] && !dec[i]) pkt_cnt[i] <= pkt_cnt[i] + CNT_W'(1);
                else if (dec[i] && !in_eop[i]) pkt_cnt[i] <= pkt_cnt[i] - CNT_W'(1);
                rdy_q[i] <= (FIFO_DEPTH - int'(fifo_cnt[i])) >= MAX_PKT_WORDS;
                err_q[i] <= err_q[i] | (in_wr[i] & fifo_full[i]);
            end
        end
    end

    // Output register: popped word goes out next cycle; data holds between packets.
    always_ff @(posedge clk) begin
        if (rst) begin
            pktout_data          <= '0;
            pktout_data_wr       <= 1'b0;
            pktout_data_valid    <= 1'b0;
            pktout_data_valid_wr <= 1'b0;
        end else begin
            pktout_data_wr       <= pop;
            pktout_data_valid_wr <= pop_last;
            pktout_data_valid    <= pop_last & head_sel[DATA_W];
            if (pop) pktout_data <= head_sel[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_pkt_mux_arb.sv
// Directed bench for pkt_mux_arb with a per-source scoreboard of expected output words.
// Latency: checks grant-to-first-word of 2 cycles and one idle cycle between packets.
// Backpressure: exercises downstream ready low/high/mid-packet and source FIFO overflow.
module tb_pkt_mux_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [133:0] s_data [3];
    logic [2:0]   s_wr;
    logic [2:0]   s_keep;
    logic [2:0]   s_eop;
    logic         out_rdy;

    logic         rdy_pgm, rdy_lcm, rdy_ssm;
    logic [133:0] pktout_data;
    logic         pktout_data_wr;
    logic         pktout_data_valid;
    logic         pktout_data_valid_wr;
    logic [2:0]   err_overflow;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int out_words = 0;

    logic [135:0] q0 [$];
    logic [135:0] q1 [$];
    logic [135:0] q2 [$];
    int sop_cyc [$];
    int sop_src [$];
    int eop_cyc [$];
    logic [133:0] last_data;

    pkt_mux_arb #(.FIFO_DEPTH(64), .MAX_PKT_WORDS(32)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .pgm2mux_data          (s_data[0]),
        .pgm2mux_data_wr       (s_wr[0]),
        .pgm2mux_data_valid    (s_keep[0]),
        .pgm2mux_data_valid_wr (s_eop[0]),
        .mux2pgm_data_ready    (rdy_pgm),
        .lcm2mux_data          (s_data[1]),
        .lcm2mux_data_wr       (s_wr[1]),
        .lcm2mux_data_valid    (s_keep[1]),
        .lcm2mux_data_valid_wr (s_eop[1]),
        .mux2lcm_data_ready    (rdy_lcm),
        .ssm2mux_data          (s_data[2]),
        .ssm2mux_data_wr       (s_wr[2]),
        .ssm2mux_data_valid    (s_keep[2]),
        .ssm2mux_data_valid_wr (s_eop[2]),
        .mux2ssm_data_ready    (rdy_ssm),
        .pktout_data           (pktout_data),
        .pktout_data_wr        (pktout_data_wr),
        .pktout_data_valid     (pktout_data_valid),
        .pktout_data_valid_wr  (pktout_data_valid_wr),
        .pktout_data_ready     (out_rdy),
        .err_overflow          (err_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: source id is carried in data[131:130] so each word is matched to its source queue.
    always @(negedge clk) begin
        logic [135:0] e;
        logic         ok;
        int           s;
        if (!rst) begin
            if (pktout_data_wr) begin
                s  = int'(pktout_data[131:130]);
                ok = 1'b0;
                e  = '0;
                case (s)
                    0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
                    1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
                    2: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
                    default: ok = 1'b0;
                endcase
                chk("sb_has_entry", {135'd0, ok}, 136'd1);
                if (ok) chk("out_word", {pktout_data_valid_wr, pktout_data_valid, pktout_data}, e);
                out_words++;
                if (pktout_data[133:132] == 2'b01) begin
                    sop_cyc.push_back(cyc);
                    sop_src.push_back(s);
                end
                if (pktout_data_valid_wr) eop_cyc.push_back(cyc);
            end else begin
                chk("idle_flags", {134'd0, pktout_data_valid_wr, pktout_data_valid}, 136'd0);
            end
        end
    end

    task automatic sb_push(input int src, input logic [135:0] v);
        case (src)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    // Drives one packet, one word per cycle, and records what the output must carry.
    task automatic send_pkt(input int src, input int n, input logic keep);
        for (int w = 0; w < n; w++) begin
            logic [133:0] d;
            logic [1:0]   h;
            logic         last;
            last = (w == n - 1);
            h    = (w == 0) ? 2'b01 : (last ? 2'b10 : 2'b11);
            d    = {h, 2'(src), $urandom, $urandom, $urandom, $urandom, 2'(w)};
            @(negedge clk);
            s_data[src] = d;
            s_wr        = '0;
            s_wr[src]   = 1'b1;
            s_eop       = '0;
            s_eop[src]  = last;
            s_keep      = '0;
            s_keep[src] = keep;
            sb_push(src, {last, last & keep, d});
            last_data = d;
        end
    endtask

    // Middle words with no end-of-packet, used to fill a FIFO without creating a packet.
    task automatic raw_write(input int src, input int n);
        for (int w = 0; w < n; w++) begin
            @(negedge clk);
            s_data[src] = {2'b11, 2'(src), 130'(w)};
            s_wr        = '0;
            s_wr[src]   = 1'b1;
            s_eop       = '0;
            s_keep      = '0;
        end
    endtask

    task automatic drv_idle(output int t);
        @(negedge clk);
        s_wr   = '0;
        s_eop  = '0;
        s_keep = '0;
        t      = cyc;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chki(tag, q0.size() + q1.size() + q2.size(), 0);
    endtask

    task automatic wait_sops(input string tag, input int n, input int budget);
        int k = 0;
        while (sop_cyc.size() < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chki(tag, sop_cyc.size(), n);
    endtask

    task automatic clear_log();
        sop_cyc.delete();
        sop_src.delete();
        eop_cyc.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int base;
        int k;
        rst     = 1'b1;
        out_rdy = 1'b0;
        s_wr    = '0;
        s_keep  = '0;
        s_eop   = '0;
        for (int i = 0; i < 3; i++) s_data[i] = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_data", {2'b00, pktout_data}, 136'd0);
        chk("rst_flags", {133'd0, pktout_data_wr, pktout_data_valid, pktout_data_valid_wr}, 136'd0);
        chk("rst_ready", {133'd0, rdy_ssm, rdy_lcm, rdy_pgm}, 136'd0);
        chk("rst_err", {133'd0, err_overflow}, 136'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {133'd0, rdy_ssm, rdy_lcm, rdy_pgm}, 136'd7);

        // Single 6-word ssm packet.
        out_rdy = 1'b1;
        clear_log();
        send_pkt(2, 6, 1'b1);
        drv_idle(t);
        wait_sops("t1_sop", 1, 50);
        wait_drain("t1_drain", 100);
        if (sop_cyc.size() == 1 && eop_cyc.size() == 1) begin
            chki("t1_latency", sop_cyc[0] - t, 2);
            chki("t1_contiguous", eop_cyc[0] - sop_cyc[0], 5);
        end
        @(negedge clk); #1;
        chk("t1_hold_data", {2'b00, pktout_data}, {2'b00, last_data});
        chk("t1_idle_wr", {135'd0, pktout_data_wr}, 136'd0);

        // Three queued packets with ready low, then round-robin release.
        out_rdy = 1'b0;
        clear_log();
        base = out_words;
        send_pkt(0, 3, 1'b0);
        send_pkt(1, 4, 1'b1);
        send_pkt(2, 2, 1'b1);
        drv_idle(t);
        repeat (6) @(negedge clk);
        #1;
        chki("t2_no_out_while_not_ready", out_words - base, 0);
        @(negedge clk);
        out_rdy = 1'b1;
        t = cyc;
        wait_sops("t2_sops", 3, 200);
        wait_drain("t2_drain", 200);
        if (sop_cyc.size() == 3 && eop_cyc.size() == 3) begin
            chki("t2_latency", sop_cyc[0] - t, 2);
            chki("t2_order0", sop_src[0], 0);
            chki("t2_order1", sop_src[1], 1);
            chki("t2_order2", sop_src[2], 2);
            chki("t2_gap01", sop_cyc[1] - eop_cyc[0], 2);
            chki("t2_gap12", sop_cyc[2] - eop_cyc[1], 2);
        end

        // Ready dropped mid-packet: packet finishes, next one waits.
        out_rdy = 1'b0;
        clear_log();
        send_pkt(0, 8, 1'b1);
        send_pkt(1, 3, 1'b0);
        drv_idle(t);
        @(negedge clk);
        out_rdy = 1'b1;
        t = cyc;
        wait_sops("t3_first_sop", 1, 50);
        out_rdy = 1'b0;
        k = 0;
        while (eop_cyc.size() < 1 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        repeat (8) @(negedge clk);
        #1;
        chki("t3_pgm_completed", q0.size(), 0);
        chki("t3_second_held", sop_cyc.size(), 1);
        if (sop_cyc.size() >= 1 && eop_cyc.size() >= 1) begin
            chki("t3_latency", sop_cyc[0] - t, 2);
            chki("t3_len", eop_cyc[0] - sop_cyc[0], 7);
        end
        out_rdy = 1'b1;
        wait_drain("t3_drain", 100);
        if (sop_src.size() == 2) chki("t3_second_src", sop_src[1], 1);

        // Overflow on lcm with no packet complete.
        base = out_words;
        raw_write(1, 32);
        drv_idle(t);
        @(negedge clk);
        chk("t4_ready_at_32", {133'd0, rdy_ssm, rdy_lcm, rdy_pgm}, 136'd7);
        raw_write(1, 1);
        drv_idle(t);
        @(negedge clk);
        chk("t4_ready_fall_33", {133'd0, rdy_ssm, rdy_lcm, rdy_pgm}, 136'd5);
        raw_write(1, 31);
        drv_idle(t);
        chk("t4_no_err_at_64", {133'd0, err_overflow}, 136'd0);
        raw_write(1, 1);
        drv_idle(t);
        chk("t4_err_65", {133'd0, err_overflow}, 136'd2);
        repeat (4) @(negedge clk);
        chk("t4_err_sticky", {133'd0, err_overflow}, 136'd2);
        chki("t4_no_output", out_words - base, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_err_cleared", {133'd0, err_overflow}, 136'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset at word 3 of a 6-word packet.
        clear_log();
        base = out_words;
        send_pkt(2, 6, 1'b1);
        drv_idle(t);
        k = 0;
        while (out_words < base + 3 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        chki("t5_reached_word3", out_words - base, 3);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("t5_rst_data", {2'b00, pktout_data}, 136'd0);
        chk("t5_rst_flags", {133'd0, pktout_data_wr, pktout_data_valid, pktout_data_valid_wr}, 136'd0);
        chk("t5_rst_ready", {133'd0, rdy_ssm, rdy_lcm, rdy_pgm}, 136'd0);
        q0.delete();
        q1.delete();
        q2.delete();
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chki("t5_fifo_empty", out_words - base, 3);
        clear_log();
        send_pkt(0, 5, 1'b1);
        drv_idle(t);
        wait_sops("t5_fresh_sop", 1, 50);
        wait_drain("t5_fresh_drain", 100);
        if (sop_cyc.size() == 1) chki("t5_fresh_latency", sop_cyc[0] - t, 2);

        // Last-word write and last-word pop on ssm in the same cycle.
        clear_log();
        send_pkt(2, 4, 1'b1);
        send_pkt(2, 5, 1'b0);
        drv_idle(t);
        wait_sops("t6_sops", 2, 100);
        wait_drain("t6_drain", 100);
        if (sop_cyc.size() == 2 && eop_cyc.size() == 2) begin
            chki("t6_gap", sop_cyc[1] - eop_cyc[0], 2);
            chki("t6_src", sop_src[1], 2);
        end
        repeat (5) @(negedge clk);
        #1;
        chki("t6_no_extra_pkt", sop_cyc.size(), 2);

        // Arbiter still serves another source afterwards.
        clear_log();
        send_pkt(1, 2, 1'b1);
        drv_idle(t);
        wait_sops("t7_sop", 1, 50);
        wait_drain("t7_drain", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
